// File: rtl/storage_loader.sv
// storage_loader: copies word_count words from a 1-cycle-latency storage drive into main memory.
// Optional running checksum output enabled by defining STORAGE_LOADER_CHECKSUM_EN.
module storage_loader #(
  parameter int DW             = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     src_base,
  input  logic [MEM_ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]       word_count,
  output logic [ADDR_WIDTH-1:0]     hd_address,
  input  logic [DW-1:0]             hd_data,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [DW-1:0]             mem_data,
  output logic                      mem_write_enable,
  output logic                      busy,
  output logic                      done
`ifdef STORAGE_LOADER_CHECKSUM_EN
  ,
  output logic [DW-1:0]             checksum
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, STORE, DONE} state_t;
  localparam logic [ADDR_WIDTH:0] MAX_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [MEM_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d, idx_q, idx_d, cnt_clamped;
  assign cnt_clamped = (word_count > MAX_CNT) ? MAX_CNT : word_count;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (start) begin
        src_d   = src_base;
        dst_d   = dst_base;
        cnt_d   = cnt_clamped;
        idx_d   = '0;
        state_d = (cnt_clamped == '0) ? DONE : FETCH;
      end
      FETCH: state_d = STORE;
      STORE: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == cnt_q - 1'b1) ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  // Address held through FETCH and STORE so the drive's registered output lines up with the write.
  assign busy             = (state_q == FETCH) || (state_q == STORE);
  assign done             = (state_q == DONE);
  assign mem_write_enable = (state_q == STORE);
  assign hd_address       = busy ? src_q + idx_q[ADDR_WIDTH-1:0] : '0;
  assign mem_address      = mem_write_enable ? dst_q + MEM_ADDR_WIDTH'(idx_q) : '0;
  assign mem_data         = mem_write_enable ? hd_data : '0;
`ifdef STORAGE_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
  always_ff @(posedge clock) begin
    if (reset) sum_q <= '0;
    else sum_q <= sum_d;
  end
  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && start) sum_d = '0;
    else if (state_q == STORE) sum_d = sum_q + hd_data;
  end
  assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_storage_loader.sv
// tb_storage_loader: directed self-checking bench for storage_loader.
module tb_storage_loader;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [13:0] src_base = '0, hd_address;
  logic [15:0] dst_base = '0, mem_address;
  logic [14:0] word_count = '0;
  logic [31:0] hd_data = '0, mem_data;
  logic mem_write_enable, busy, done;
`ifdef STORAGE_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int checks = 0, errors = 0, cyc = 0, s_cyc = 0, done_n = 0, done_rel = 0, busy_n = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  logic [13:0] ra[$];

  storage_loader dut (
    .clock(clock), .reset(reset), .start(start), .src_base(src_base), .dst_base(dst_base),
    .word_count(word_count), .hd_address(hd_address), .hd_data(hd_data),
    .mem_address(mem_address), .mem_data(mem_data), .mem_write_enable(mem_write_enable),
    .busy(busy), .done(done)
`ifdef STORAGE_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock)
    hd_data <= (hd_address == 14'h200) ? 32'hFFFF_FFFF :
               (hd_address == 14'h201) ? 32'h0000_0002 : (32'hDA7A_0000 | 32'(hd_address));
  always @(negedge clock) begin
    if (mem_write_enable) begin
      wa.push_back(mem_address);
      wd.push_back(mem_data);
      ra.push_back(hd_address);
    end
    if (busy) busy_n++;
    if (done) begin
      done_n++;
      done_rel = cyc - s_cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); ra.delete();
    done_n = 0; done_rel = 0; busy_n = 0;
  endtask

  task automatic kick(input logic [13:0] s, input logic [15:0] d, input logic [14:0] n);
    @(negedge clock);
    src_base = s; dst_base = d; word_count = n; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    s_cyc = cyc;
    clear_logs();
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      #1;
      if (done_n != 0) break;
    end
    repeat (3) @(negedge clock);
    #1;
  endtask

  initial begin
    logic [13:0] e_ra[3];
    logic [15:0] e_wa[3];
    logic [31:0] e_wd[3];
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_hd_addr", hd_address, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_data", mem_data, 0);

    kick(14'h0010, 16'h0100, 15'd4);
    wait_done(30);
    chk("t1_writes", wa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", wa[i], 16'h0100 + i);
      chk("t1_data", wd[i], 32'hDA7A_0010 + i);
    end
    chk("t1_done_cycle", done_rel, 9);
    chk("t1_done_pulses", done_n, 1);
    chk("t1_busy_cycles", busy_n, 8);
    chk("t1_idle_busy", busy, 0);

    kick(14'h0005, 16'h0005, 15'd0);
    wait_done(10);
    chk("t0_writes", wa.size(), 0);
    chk("t0_done_cycle", done_rel, 1);
    chk("t0_done_pulses", done_n, 1);
    chk("t0_busy_cycles", busy_n, 0);

    kick(14'h3FFE, 16'hFFFF, 15'd3);
    wait_done(30);
    e_ra = '{14'h3FFE, 14'h3FFF, 14'h0000};
    e_wa = '{16'hFFFF, 16'h0000, 16'h0001};
    e_wd = '{32'hDA7A_3FFE, 32'hDA7A_3FFF, 32'hDA7A_0000};
    chk("wrap_writes", wa.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_rd_addr", ra[i], e_ra[i]);
      chk("wrap_wr_addr", wa[i], e_wa[i]);
      chk("wrap_data", wd[i], e_wd[i]);
    end
    chk("wrap_done_cycle", done_rel, 7);

    kick(14'h0020, 16'h0300, 15'd3);
    repeat (2) @(negedge clock);
    src_base = 14'h0030; dst_base = 16'h0400; word_count = 15'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(30);
    chk("ign_writes", wa.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("ign_addr", wa[i], 16'h0300 + i);
      chk("ign_data", wd[i], 32'hDA7A_0020 + i);
    end
    chk("ign_done_cycle", done_rel, 7);
    chk("ign_done_pulses", done_n, 1);

    kick(14'h0040, 16'h0500, 15'd5);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    chk("rstmid_writes", wa.size(), 3);
    chk("rstmid_last_addr", wa[2], 16'h0502);
    chk("rstmid_last_data", wd[2], 32'hDA7A_0042);
    chk("rstmid_done", done_n, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_we", mem_write_enable, 0);

    @(negedge clock);
    reset = 1'b1; start = 1'b1; src_base = 14'h0001; dst_base = 16'h0001; word_count = 15'd2;
    @(posedge clock);
    #1 reset = 1'b0; start = 1'b0;
    clear_logs();
    repeat (4) @(negedge clock);
    #1;
    chk("rststart_busy", busy_n, 0);
    chk("rststart_done", done_n, 0);
    chk("rststart_writes", wa.size(), 0);

    kick(14'h0000, 16'h0000, 15'h7FFF);
    wait_done(40000);
    chk("clamp_writes", wa.size(), 16384);
    chk("clamp_last_addr", wa[16383], 16'h3FFF);
    chk("clamp_last_data", wd[16383], 32'hDA7A_3FFF);
    chk("clamp_done_cycle", done_rel, 32769);

`ifdef STORAGE_LOADER_CHECKSUM_EN
    kick(14'h0200, 16'h0010, 15'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) break;
    end
    chk("csum_at_done", checksum, 32'h0000_0001);
    repeat (3) @(negedge clock);
    chk("csum_stable", checksum, 32'h0000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
